irq_gateway: RTL

//  Conditions raw external interrupt lines before they reach the PLIC interrupt inputs.
//  - Synchronises each line to i_clock; optional glitch filter.
//  - Applies per-source polarity, edge/level mode and mask.
//  - Keeps sticky edge status and saturating edge counters, readable over the CPU bus.
//  - o_irq[i] drives the PLIC input for source i+1.

---
 rtl/irq_pkg.sv | 24 ++
 rtl/irq_sync_edge.sv | 83 ++++++++
 rtl/irq_gateway.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt gateway: register offsets, source mode
// encoding, the counter type and a helper that returns the CNT[i] address.
package irq_pkg;

  localparam int unsigned IRQ_MAX_SOURCES = 8;

  // Byte offsets within the block
  localparam logic [23:0] IRQ_MODE_OFS   = 24'h00;
  localparam logic [23:0] IRQ_POL_OFS    = 24'h04;
  localparam logic [23:0] IRQ_MASK_OFS   = 24'h08;
  localparam logic [23:0] IRQ_RAW_OFS    = 24'h0C;
  localparam logic [23:0] IRQ_STATUS_OFS = 24'h10;
  localparam logic [23:0] IRQ_CNT_OFS    = 24'h20;

  typedef enum logic {IRQ_LEVEL = 1'b0, IRQ_EDGE = 1'b1} irq_mode_t;

  typedef logic [7:0] irq_cnt_t;
  localparam irq_cnt_t IRQ_CNT_MAX = 8'hFF;

  function automatic logic [23:0] irq_cnt_addr(input int unsigned idx);
    return IRQ_CNT_OFS + 24'(idx * 4);
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Single-source front end: synchroniser, optional glitch filter, polarity
// and rising-edge detection.
// Optional feature macro: IRQ_GATEWAY_GLITCH_FILTER_EN (adds the glitch filter).
// Ports:
//   clk_i    clock
//   rst_ni   asynchronous active-low reset
//   raw_i    asynchronous interrupt pin
//   pol_i    1 = active-low source
//   level_o  conditioned, post-polarity level (combinational from flops)
//   rise_o   one-cycle strobe on a 0->1 of level_o
module irq_sync_edge #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  input  logic pol_i,
  output logic level_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   cond;   // synchronised (and filtered) pre-polarity sample
  logic                   hist_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
    end
  end

`ifdef IRQ_GATEWAY_GLITCH_FILTER_EN
  logic       filt_q, filt_d;
  logic [3:0] fcnt_q, fcnt_d;

  // Output follows the input only after FILTER_CYCLES consecutive differing samples
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (sync_q[SYNC_STAGES-1] != filt_q) begin
      if (fcnt_q == 4'(FILTER_CYCLES - 1)) begin
        filt_d = sync_q[SYNC_STAGES-1];
      end else begin
        fcnt_d = fcnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      filt_q <= 1'b0;
      fcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign cond = filt_q;
`else
  logic unused_filter;
  assign unused_filter = ^(4'(FILTER_CYCLES));
  assign cond = sync_q[SYNC_STAGES-1];
`endif

  // History holds the pre-polarity sample and is compared through the current
  // polarity, so a POL change is equivalent to reloading the history with the
  // new-polarity level and never produces a spurious edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hist_q <= 1'b0;
    end else begin
      hist_q <= cond;
    end
  end

  assign level_o = cond ^ pol_i;
  assign rise_o  = level_o & ~(hist_q ^ pol_i);

endmodule

// File: rtl/irq_gateway.sv
// Interrupt gateway: conditions raw external lines for the PLIC inputs and
// exposes mode/polarity/mask, sticky status and saturating edge counters on a
// simple request/ready bus. o_irq[i] drives PLIC source i+1.
// Optional feature macro: IRQ_GATEWAY_GLITCH_FILTER_EN (per-source glitch filter).
// Ports:
//   i_clock, i_reset_n   clock, asynchronous active-low reset
//   i_irq_raw / o_irq    raw lines in, conditioned interrupts out
//   i_request, i_rw      access strobe, 1 = write
//   i_address, i_wdata   byte address, write data
//   o_rdata, o_ready     read data (valid only with o_ready), access done
module irq_gateway
  import irq_pkg::*;
#(
  parameter int unsigned NUM_SOURCES   = 4,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 4
) (
  input  logic                   i_clock,
  input  logic                   i_reset_n,
  input  logic [NUM_SOURCES-1:0] i_irq_raw,
  output logic [NUM_SOURCES-1:0] o_irq,
  input  logic                   i_request,
  input  logic                   i_rw,
  input  logic [23:0]            i_address,
  input  logic [31:0]            i_wdata,
  output logic [31:0]            o_rdata,
  output logic                   o_ready
);

  logic [NUM_SOURCES-1:0] mode_q, mode_d;
  logic [NUM_SOURCES-1:0] pol_q, pol_d;
  logic [NUM_SOURCES-1:0] mask_q, mask_d;
  logic [NUM_SOURCES-1:0] status_q, status_d;
  irq_cnt_t               cnt_q [NUM_SOURCES];
  irq_cnt_t               cnt_d [NUM_SOURCES];
  logic [NUM_SOURCES-1:0] irq_q, irq_d;
  logic [31:0]            rdata_q, rdata_d;
  logic                   ready_q;

  logic [NUM_SOURCES-1:0] level;
  logic [NUM_SOURCES-1:0] rise;
  logic                   wr_en, rd_en;
  logic [NUM_SOURCES-1:0] wdata_src;
  logic                   unused_wdata;

  for (genvar g = 0; g < NUM_SOURCES; g++) begin : gen_src
    irq_sync_edge #(
      .SYNC_STAGES   (SYNC_STAGES),
      .FILTER_CYCLES (FILTER_CYCLES)
    ) u_sync_edge (
      .clk_i   (i_clock),
      .rst_ni  (i_reset_n),
      .raw_i   (i_irq_raw[g]),
      .pol_i   (pol_q[g]),
      .level_o (level[g]),
      .rise_o  (rise[g])
    );
  end

  assign wr_en        = i_request & i_rw;
  assign rd_en        = i_request & ~i_rw;
  assign wdata_src    = i_wdata[NUM_SOURCES-1:0];
  assign unused_wdata = ^i_wdata;

  // Register file and counters
  always_comb begin
    mode_d   = mode_q;
    pol_d    = pol_q;
    mask_d   = mask_q;
    status_d = status_q;
    if (wr_en && (i_address == IRQ_MODE_OFS)) mode_d = wdata_src;
    if (wr_en && (i_address == IRQ_POL_OFS))  pol_d  = wdata_src;
    if (wr_en && (i_address == IRQ_MASK_OFS)) mask_d = wdata_src;
    // A new edge wins over a same-cycle W1C
    if (wr_en && (i_address == IRQ_STATUS_OFS)) status_d = status_q & ~wdata_src;
    status_d = status_d | rise;

    for (int i = 0; i < NUM_SOURCES; i++) begin
      cnt_d[i] = cnt_q[i];
      if (wr_en && (i_address == irq_cnt_addr(i))) begin
        cnt_d[i] = rise[i] ? irq_cnt_t'(1) : '0;
      end else if (rise[i] && (cnt_q[i] != IRQ_CNT_MAX)) begin
        cnt_d[i] = cnt_q[i] + irq_cnt_t'(1);
      end
    end
  end

  // Conditioned outputs
  always_comb begin
    irq_d = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      irq_d[i] = ~mask_q[i] &
                 ((irq_mode_t'(mode_q[i]) == IRQ_EDGE) ? rise[i] : level[i]);
    end
  end

  // Read mux; data is zero outside the ready cycle
  always_comb begin
    rdata_d = '0;
    if (rd_en) begin
      case (i_address)
        IRQ_MODE_OFS:   rdata_d = 32'(mode_q);
        IRQ_POL_OFS:    rdata_d = 32'(pol_q);
        IRQ_MASK_OFS:   rdata_d = 32'(mask_q);
        IRQ_RAW_OFS:    rdata_d = 32'(level);
        IRQ_STATUS_OFS: rdata_d = 32'(status_q);
        default: begin
          for (int i = 0; i < NUM_SOURCES; i++) begin
            if (i_address == irq_cnt_addr(i)) rdata_d = 32'(cnt_q[i]);
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      mode_q   <= '0;
      pol_q    <= '0;
      mask_q   <= '0;
      status_q <= '0;
      irq_q    <= '0;
      rdata_q  <= '0;
      ready_q  <= 1'b0;
      for (int i = 0; i < NUM_SOURCES; i++) cnt_q[i] <= '0;
    end else begin
      mode_q   <= mode_d;
      pol_q    <= pol_d;
      mask_q   <= mask_d;
      status_q <= status_d;
      irq_q    <= irq_d;
      rdata_q  <= rdata_d;
      ready_q  <= i_request;
      for (int i = 0; i < NUM_SOURCES; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign o_irq   = irq_q;
  assign o_rdata = rdata_q;
  assign o_ready = ready_q;

endmodule
